snake_game_ctrl: RTL and testbench

Game-flow sequencer for the snake engine. Owns the idle/play/pause/over state machine, drives the engine reset, generates the move_tick pulse with a period that shrinks as the snake grows, and buffers player turns in a 2-entry queue so quick double-turns are not lost between ticks. Sits between the board keys and the snake engine; replaces the free-running tick counter and the raw direction register in the top level.

---
 rtl/snake_game_ctrl_if.sv | 33 +++
 rtl/snake_game_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_game_ctrl_if.sv
// ============================================================================
// Module   : snake_game_ctrl_if
// Purpose  : Key inputs and engine-facing signals of the snake game controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface snake_game_ctrl_if;
  logic [3:0] key_dir;
  logic       key_start;
  logic       key_pause;
  logic       game_over;
  logic [6:0] snake_length;
  logic       engine_reset;
  logic       move_tick;
  logic [1:0] direction;
  logic [1:0] state;
  logic [3:0] speed_level;

  // Controller side
  modport master (
    input  key_dir, key_start, key_pause, game_over, snake_length,
    output engine_reset, move_tick, direction, state, speed_level
  );

  // Board/engine side
  modport slave (
    output key_dir, key_start, key_pause, game_over, snake_length,
    input  engine_reset, move_tick, direction, state, speed_level
  );
endinterface

`default_nettype wire

// File: rtl/snake_game_ctrl.sv
// ============================================================================
// Module   : snake_game_ctrl
// Purpose  : Game-flow FSM, length-scaled move tick and 2-entry turn queue.
//            Optional macro SNAKE_SPEEDUP_EN enables length-based speed-up.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module snake_game_ctrl #(
  parameter int TICK_BASE = 6250000,
  parameter int TICK_STEP = 250000,
  parameter int TICK_MIN  = 2500000,
  parameter int LEN_START = 10,
  parameter int CNT_W     = 23
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  snake_game_ctrl_if.master  bus
);

  localparam int c_per_w = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_eng_rst;
  logic             r_tick;
  logic [1:0]       r_dir;
  logic [3:0]       r_speed;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [1:0]       r_q0;
  logic [1:0]       r_q1;
  logic [1:0]       r_qcnt;

  logic [5:0] w_keys;
  logic [5:0] r_sync1, r_sync2, r_sync3, r_edge;

  logic [3:0]       w_dir_edge;
  logic             w_start_edge;
  logic             w_pause_edge;
  logic [1:0]       w_req;
  logic [1:0]       w_tail;
  logic [1:0]       w_ref;
  logic             w_push;
  logic             w_pop;
  logic             w_wrap;
  logic [1:0]       w_qcnt_after_pop;
  logic [CNT_W-1:0] w_period;
  logic [3:0]       w_speed;

  assign w_keys = {bus.key_pause, bus.key_start, bus.key_dir};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  assign w_dir_edge   = r_edge[3:0];
  assign w_start_edge = r_edge[4];
  assign w_pause_edge = r_edge[5];

`ifdef SNAKE_SPEEDUP_EN
  logic [4:0]         w_level;
  logic [c_per_w-1:0] w_dec;
  logic [c_per_w-1:0] w_sub;

  always_comb begin
    w_level = 5'((bus.snake_length - 7'(LEN_START)) >> 2);
    if (bus.snake_length <= 7'(LEN_START))
      w_speed = 4'd0;
    else if (w_level > 5'd15)
      w_speed = 4'd15;
    else
      w_speed = w_level[3:0];
  end

  // The extra bit plus the explicit compare keeps the subtraction from wrapping.
  always_comb begin
    w_dec = c_per_w'(TICK_STEP) * c_per_w'(r_speed);
    w_sub = c_per_w'(TICK_BASE) - w_dec;
    if (w_dec >= c_per_w'(TICK_BASE) || w_sub < c_per_w'(TICK_MIN))
      w_period = CNT_W'(TICK_MIN);
    else
      w_period = w_sub[CNT_W-1:0];
  end
`else
  localparam int c_unused_cfg = TICK_STEP + TICK_MIN + LEN_START;
  logic w_unused_len;

  assign w_unused_len = ^bus.snake_length;
  assign w_speed      = 4'd0;
  assign w_period     = CNT_W'(TICK_BASE);
`endif

  always_comb begin
    casez (w_dir_edge)
      4'b???1: w_req = 2'd0;
      4'b??10: w_req = 2'd1;
      4'b?100: w_req = 2'd2;
      default: w_req = 2'd3;
    endcase
    w_tail = (r_qcnt == 2'd2) ? r_q1 : r_q0;
    w_ref  = (r_qcnt != 2'd0) ? w_tail : r_dir;
    w_push = (|w_dir_edge) && (w_req != w_ref) && (w_req != (w_ref ^ 2'b10))
             && (r_qcnt != 2'd2);
    w_wrap = (r_cnt == r_period - CNT_W'(1));
    w_pop  = w_wrap && (r_qcnt != 2'd0);
    w_qcnt_after_pop = r_qcnt - {1'b0, w_pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_eng_rst <= 1'b1;
      r_tick    <= 1'b0;
      r_dir     <= 2'b01;
      r_speed   <= 4'd0;
      r_cnt     <= '0;
      r_period  <= CNT_W'(TICK_BASE);
      r_q0      <= 2'd0;
      r_q1      <= 2'd0;
      r_qcnt    <= 2'd0;
    end else begin
      r_tick  <= 1'b0;
      r_speed <= w_speed;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state   <= S_PLAY;
            r_eng_rst <= 1'b0;
            r_cnt     <= '0;
            r_period  <= w_period;
            r_dir     <= 2'b01;
            r_qcnt    <= 2'd0;
          end
        end
        S_PLAY: begin
          if (bus.game_over) begin
            r_state <= S_OVER;
          end else if (w_pause_edge) begin
            r_state <= S_PAUSE;
          end else begin
            r_tick <= w_wrap;
            if (w_wrap) begin
              r_cnt    <= '0;
              r_period <= w_period;
              if (w_pop)
                r_dir <= r_q0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_pop)
              r_q0 <= r_q1;
            // A push landing after a pop that empties the queue becomes the new head.
            if (w_push) begin
              if (w_qcnt_after_pop == 2'd0)
                r_q0 <= w_req;
              else
                r_q1 <= w_req;
            end
            r_qcnt <= w_qcnt_after_pop + {1'b0, w_push};
          end
        end
        S_PAUSE: begin
          if (bus.game_over)
            r_state <= S_OVER;
          else if (w_pause_edge)
            r_state <= S_PLAY;
        end
        default: begin
          if (w_start_edge) begin
            r_state   <= S_IDLE;
            r_eng_rst <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.engine_reset = r_eng_rst;
  assign bus.move_tick    = r_tick;
  assign bus.direction    = r_dir;
  assign bus.state        = r_state;
  assign bus.speed_level  = r_speed;

endmodule

`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
// ============================================================================
// Module   : tb_snake_game_ctrl
// Purpose  : Directed plus randomized bench for snake_game_ctrl with a
//            behavioural game model. Honours SNAKE_SPEEDUP_EN like the design.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_snake_game_ctrl;

  localparam int TB_BASE = 20;
  localparam int TB_STEP = 4;
  localparam int TB_MIN  = 8;
  localparam int TB_LS   = 10;
  localparam int TB_CW   = 5;

  logic clk = 1'b0;
  logic reset_n;

  snake_game_ctrl_if bus();

  snake_game_ctrl #(
    .TICK_BASE(TB_BASE),
    .TICK_STEP(TB_STEP),
    .TICK_MIN (TB_MIN),
    .LEN_START(TB_LS),
    .CNT_W    (TB_CW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  // Game model: state 0 idle, 1 play, 2 pause, 3 over
  int         m_state, m_cnt, m_per, m_dir, m_spd, m_tick;
  logic [1:0] m_q[$];
  logic [5:0] m_hist[4];

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int spd_of(int len);
`ifdef SNAKE_SPEEDUP_EN
    int lvl;
    if (len <= TB_LS) return 0;
    lvl = (len - TB_LS) / 4;
    return (lvl > 15) ? 15 : lvl;
`else
    return 0;
`endif
  endfunction

  function automatic int per_of(int lvl);
`ifdef SNAKE_SPEEDUP_EN
    int p;
    p = TB_BASE - TB_STEP * lvl;
    return (p < TB_MIN) ? TB_MIN : p;
`else
    return TB_BASE;
`endif
  endfunction

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_per = TB_BASE; m_dir = 1; m_spd = 0; m_tick = 0;
    m_q.delete();
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
  endfunction

  // One clock of the game rules; a key press is acted on 3 clocks after it is sampled.
  function automatic void model_step();
    logic [5:0] k, e;
    logic [1:0] req, refd;
    bit         push_ok;
    int         nspd;
    if (!reset_n) begin
      model_reset();
      return;
    end
    k = {bus.key_pause, bus.key_start, bus.key_dir};
    e = m_hist[2] & ~m_hist[3];
    m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = k;
    nspd   = spd_of(int'(bus.snake_length));
    m_tick = 0;
    case (m_state)
      0: if (e[4]) begin
           m_state = 1; m_cnt = 0; m_dir = 1; m_per = per_of(m_spd);
           m_q.delete();
         end
      1: if (bus.game_over) m_state = 3;
         else if (e[5]) m_state = 2;
         else begin
           push_ok = 0;
           req = 2'd0;
           if (e[3:0] != 4'd0) begin
             req  = e[0] ? 2'd0 : e[1] ? 2'd1 : e[2] ? 2'd2 : 2'd3;
             refd = (m_q.size() != 0) ? m_q[m_q.size()-1] : 2'(m_dir);
             push_ok = (req != refd) && (req != (refd ^ 2'b10)) && (m_q.size() < 2);
           end
           if (m_cnt == m_per - 1) begin
             m_tick = 1; m_cnt = 0; m_per = per_of(m_spd);
             if (m_q.size() != 0) m_dir = int'(m_q.pop_front());
           end else begin
             m_cnt++;
           end
           if (push_ok) m_q.push_back(req);
         end
      2: if (bus.game_over) m_state = 3;
         else if (e[5]) m_state = 1;
      default: if (e[4]) m_state = 0;
    endcase
    m_spd = nspd;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state",        int'(bus.state),        m_state);
      chk("engine_reset", int'(bus.engine_reset), (m_state == 0) ? 1 : 0);
      chk("move_tick",    int'(bus.move_tick),    m_tick);
      chk("direction",    int'(bus.direction),    m_dir);
      chk("speed_level",  int'(bus.speed_level),  m_spd);
    end
  end

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic press(int bitn);
    logic [5:0] k;
    k = {bus.key_pause, bus.key_start, bus.key_dir};
    k[bitn] = 1'b1;
    {bus.key_pause, bus.key_start, bus.key_dir} = k;
    step(2);
    k[bitn] = 1'b0;
    {bus.key_pause, bus.key_start, bus.key_dir} = k;
    step(2);
  endtask

  task automatic wait_tick(output int gap);
    gap = 0;
    do begin
      step();
      gap++;
    end while (bus.move_tick !== 1'b1 && gap < 200);
    if (bus.move_tick !== 1'b1) chk("tick_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_state"}, int'(bus.state),        0);
    chk({tag, "_eng"},   int'(bus.engine_reset), 1);
    chk({tag, "_tick"},  int'(bus.move_tick),    0);
    chk({tag, "_dir"},   int'(bus.direction),    1);
    chk({tag, "_speed"}, int'(bus.speed_level),  0);
  endtask

  initial begin
    int gap, ticks, guard;
    logic [3:0] kd;
    reset_n = 1'b0;
    bus.key_dir = 4'd0; bus.key_start = 1'b0; bus.key_pause = 1'b0;
    bus.game_over = 1'b0; bus.snake_length = 7'd10;
    model_reset();
    step(3);
    cmp_en = 1'b1;
    chk_reset_vals("reset");
    reset_n = 1'b1;
    step(2);

    // Start a game, nominal period
    press(4);
    chk("play_state", int'(bus.state), 1);
    chk("play_eng",   int'(bus.engine_reset), 0);
    wait_tick(gap);
    wait_tick(gap);
    chk("period_base", gap, 20);
    chk("dir_start", int'(bus.direction), 1);

    // Double turn within one tick, third turn dropped
    press(0); press(3); press(2);
    wait_tick(gap);
    chk("dir_first_turn", int'(bus.direction), 0);
    wait_tick(gap);
    chk("dir_second_turn", int'(bus.direction), 3);
    wait_tick(gap);
    chk("dir_dropped_turn", int'(bus.direction), 3);

    // Back to right, then a reversing request is rejected
    press(0); press(1);
    wait_tick(gap);
    wait_tick(gap);
    chk("dir_right", int'(bus.direction), 1);
    press(3);
    for (int i = 0; i < 3; i++) begin
      wait_tick(gap);
      chk("dir_no_reverse", int'(bus.direction), 1);
    end

    // Speed-up with length, then clamp
    bus.snake_length = 7'd14;
    step(2);
`ifdef SNAKE_SPEEDUP_EN
    chk("speed_14", int'(bus.speed_level), 1);
    wait_tick(gap); wait_tick(gap);
    chk("period_14", gap, 16);
`else
    chk("speed_14", int'(bus.speed_level), 0);
    wait_tick(gap); wait_tick(gap);
    chk("period_14", gap, 20);
`endif
    bus.snake_length = 7'd40;
    step(2);
`ifdef SNAKE_SPEEDUP_EN
    chk("speed_40", int'(bus.speed_level), 7);
    wait_tick(gap); wait_tick(gap);
    chk("period_40", gap, 8);
`else
    chk("speed_40", int'(bus.speed_level), 0);
    wait_tick(gap); wait_tick(gap);
    chk("period_40", gap, 20);
`endif
    bus.snake_length = 7'd10;
    step(2);
    wait_tick(gap);

    // Pause mid-period: no ticks while paused, counting resumes afterwards
    guard = 0;
    while (m_cnt != 2 && guard < 100) begin step(); guard++; end
    bus.key_pause = 1'b1;
    step(2);
    bus.key_pause = 1'b0;
    step(2);
    chk("pause_state", int'(bus.state), 2);
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.move_tick === 1'b1) ticks++;
    end
    chk("pause_ticks", ticks, 0);
    press(5);
    chk("resume_state", int'(bus.state), 1);
    wait_tick(gap);

    // game_over on the wrap cycle suppresses the tick
    guard = 0;
    while (!(m_state == 1 && m_cnt == m_per - 1) && guard < 100) begin step(); guard++; end
    bus.game_over = 1'b1;
    step();
    chk("over_tick",  int'(bus.move_tick), 0);
    chk("over_state", int'(bus.state), 3);
    bus.game_over = 1'b0;
    press(4);
    chk("over_to_idle", int'(bus.state), 0);
    chk("idle_eng",     int'(bus.engine_reset), 1);
    press(4);
    chk("restart_state", int'(bus.state), 1);
    step(3);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("async_reset");
    step(2);
    reset_n = 1'b1;

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        kd = bus.key_dir;
        kd[$urandom_range(0, 3)] ^= 1'b1;
        if ($urandom_range(0, 3) == 0) kd[$urandom_range(0, 3)] ^= 1'b1;
        bus.key_dir = kd;
      end
      if ($urandom_range(0, 11) == 0) bus.key_start = ~bus.key_start;
      if ($urandom_range(0, 39) == 0) bus.key_pause = ~bus.key_pause;
      bus.game_over = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) bus.snake_length = 7'($urandom_range(0, 70));
      if ($urandom_range(0, 1199) == 0) begin
        reset_n = 1'b0;
        model_reset();
        step(2);
        reset_n = 1'b1;
      end
      step();
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
